pwm_multi_generator: RTL and testbench
======================================

PWM_MULTI_GENERATOR -- requirements
Module: pwm_multi_generator

Interface
REQ-001 Parameter WIDTH, default 10, SHALL set the counter, period and duty width in bits.
REQ-002 Parameter CHANNELS, default 4, SHALL set the number of independent PWM outputs (1..16).
REQ-003 CLK  input  1  SHALL be the clock; all state changes occur on its rising edge.
REQ-004 reset  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 enable  input  1  SHALL run the counter when high.
REQ-006 center_mode  input  1  SHALL select the alignment: 0 = edge-aligned, 1 = center-aligned.
REQ-007 period  input  WIDTH  SHALL be the requested terminal count.
REQ-008 wr_en  input  1  SHALL be the duty write request.
REQ-009 wr_ch  input  max(1,clog2(CHANNELS))  SHALL be the channel index for the write.
REQ-010 wr_duty  input  WIDTH  SHALL be the duty value to write.
REQ-011 wr_ready  output  1  SHALL indicate that a write is accepted this cycle.
REQ-012 pwm  output  CHANNELS  SHALL carry the registered PWM outputs.
REQ-013 period_end  output  1  SHALL be a one-cycle registered pulse marking a period boundary.
REQ-014 count  output  WIDTH  SHALL expose the current counter value.

Function
REQ-015 State: counter cnt, direction dir, active period P_act, active mode M_act, per-channel shadow duty S[i], and active duty D_act[i].
REQ-016 Write handshake: a write is accepted when wr_en=1 and wr_ready=1; on acceptance S[wr_ch] <= wr_duty, unless wr_ch >= CHANNELS, in which case the write is ignored.
REQ-017 Terminal cycle definitions:
- Edge mode: enable=1 and cnt==P_act.
- Center mode: enable=1, dir=down and cnt==1; or P_act==0.
REQ-018 wr_ready SHALL be 0 during a terminal cycle and 1 otherwise; a write presented while wr_ready=0 SHALL be dropped, and the master holds it.
REQ-019 Edge mode: cnt increments by 1 each cycle from 0 to P_act; the period is P_act+1 cycles.
REQ-020 Center mode, counting:
- Up from 0 to P_act.
- dir flips to down at P_act.
- Down to 1.
- Period is 2*P_act cycles.
REQ-021 Center mode, dir flip: dir SHALL flip to down when cnt reaches P_act, and flip back to up at the terminal cycle.
REQ-022 At the end of a terminal cycle:
- cnt <= 0, dir <= up.
- P_act <= period, M_act <= center_mode.
- D_act[i] <= S[i] for every channel.
- period_end <= 1 for exactly one cycle.
REQ-023 pwm[i] <= (cnt < D_act[i]) on every enabled edge, so pwm lags count by one cycle; the comparison is unsigned.
REQ-024 Duty bounds:
- D_act[i]==0 SHALL give a constant 0.
- D_act[i] > P_act SHALL give a constant 1 (100% duty).
- There SHALL be no glitch at the wrap.
REQ-025 Counter arithmetic SHALL stay within WIDTH bits; with period = 2^WIDTH-1 the counter SHALL wrap to 0 via the terminal rule, never via overflow.
REQ-026 enable=0 SHALL apply all of the following:
- cnt=0, dir=up.
- pwm=0, period_end=0.
- P_act, M_act and D_act reloaded every cycle from period, center_mode and S.
- Writes still accepted.
REQ-027 After enable rises, the first enabled cycle SHALL have cnt=0.
REQ-028 Changes to period, center_mode or S mid-period SHALL affect only the next period.

Reset
REQ-029 While reset=1, the following SHALL be 0 immediately, independent of CLK: cnt, dir (up), P_act, M_act, all S[i], all D_act[i], pwm, period_end and count.
REQ-030 reset asserted mid-period SHALL abort the period with no residual pulse; operation SHALL resume from cnt=0 at the first enabled edge after release.

Verification (WIDTH=10, CHANNELS=4)
REQ-031 Edge duty: period=9, S[0]=3, enable=1 -> pwm[0] is 3 high / 7 low, repeating; period_end every 10 cycles.
REQ-032 Duty bounds: period=9 with S[1]=0 and S[2]=10 -> pwm[1] constant 0 and pwm[2] constant 1 across at least 3 periods.
REQ-033 Shadow and handshake:
- Write S[0]=5 at cnt=4 -> pwm[0] width unchanged until the next boundary, then 5.
- Write during the terminal cycle -> wr_ready=0 and S unchanged.
- Write with wr_ch=5 -> ignored.
REQ-034 Center mode: period=4, S[0]=2 -> count sequence 0,1,2,3,4,3,2,1 repeating; pwm[0] high 3 of 8 cycles; period_end every 8 cycles.
REQ-035 Async reset: assert reset at cnt=6 of period 9, between clock edges -> pwm, count and period_end go to 0 before the next edge; after release, S reads as zero (all pwm low).
REQ-036 Enable: drop enable mid-period -> pwm=0 and count=0 next edge; re-raise it -> count starts at 0 with the latest period and S values.

Source files
------------

// File: rtl/pwm_multi_generator.sv
// Multi-channel PWM generator with a shared counter.
//
// Ports:
//   CLK         - clock, all state changes on the rising edge
//   reset       - asynchronous, active-high reset
//   enable      - runs the counter; when low the block idles at cnt=0
//   center_mode - 0 = edge-aligned, 1 = center-aligned (takes effect next period)
//   period      - requested terminal count (takes effect next period)
//   wr_en       - duty write request
//   wr_ch       - channel index for the write (out-of-range indices are ignored)
//   wr_duty     - duty value written into the channel's shadow register
//   wr_ready    - low only during a terminal cycle; writes are dropped then
//   pwm         - registered PWM outputs, one per channel
//   period_end  - one-cycle registered pulse after each period boundary
//   count       - current counter value
module pwm_multi_generator #(
  parameter int unsigned WIDTH    = 10,
  parameter int unsigned CHANNELS = 4,
  localparam int unsigned CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic                enable,
  input  logic                center_mode,
  input  logic [WIDTH-1:0]    period,
  input  logic                wr_en,
  input  logic [CW-1:0]       wr_ch,
  input  logic [WIDTH-1:0]    wr_duty,
  output logic                wr_ready,
  output logic [CHANNELS-1:0] pwm,
  output logic                period_end,
  output logic [WIDTH-1:0]    count
);

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  dir_e                dir_q, dir_d;
  logic [WIDTH-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]    p_act_q, p_act_d;
  logic                m_act_q, m_act_d;
  logic [WIDTH-1:0]    s_q     [CHANNELS];
  logic [WIDTH-1:0]    s_d     [CHANNELS];
  logic [WIDTH-1:0]    d_act_q [CHANNELS];
  logic [WIDTH-1:0]    d_act_d [CHANNELS];
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic                period_end_q, period_end_d;

  logic                terminal;
  logic [WIDTH-1:0]    cnt_inc, cnt_dec;

  assign cnt_inc = cnt_q + WIDTH'(1);
  assign cnt_dec = cnt_q - WIDTH'(1);

  // Last cycle of a period. In center mode dir turns down on the same edge
  // that cnt reaches P_act, so P_act==1 still terminates at cnt==1 (down).
  always_comb begin
    terminal = 1'b0;
    if (enable) begin
      if (m_act_q) begin
        terminal = ((dir_q == DIR_DOWN) && (cnt_q == WIDTH'(1))) || (p_act_q == '0);
      end else begin
        terminal = (cnt_q == p_act_q);
      end
    end
  end

  assign wr_ready = ~terminal;

  // Shadow duty registers. Matching against each legal index means an
  // out-of-range wr_ch simply selects nothing.
  always_comb begin
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      s_d[i] = s_q[i];
    end
    if (wr_en && wr_ready) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (wr_ch == CW'(i)) begin
          s_d[i] = wr_duty;
        end
      end
    end
  end

  always_comb begin
    cnt_d        = cnt_q;
    dir_d        = dir_q;
    p_act_d      = p_act_q;
    m_act_d      = m_act_q;
    d_act_d      = d_act_q;
    pwm_d        = '0;
    period_end_d = 1'b0;

    // Idle and period boundary share the same reload: counter home, and
    // period/mode/duties latched from their requested values.
    if (!enable || terminal) begin
      cnt_d   = '0;
      dir_d   = DIR_UP;
      p_act_d = period;
      m_act_d = center_mode;
      d_act_d = s_q;
    end else if (m_act_q) begin
      if (dir_q == DIR_UP) begin
        cnt_d = cnt_inc;
        if (cnt_inc == p_act_q) begin
          dir_d = DIR_DOWN;
        end
      end else begin
        cnt_d = cnt_dec;
      end
    end else begin
      cnt_d = cnt_inc;
    end

    if (enable) begin
      period_end_d = terminal;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        pwm_d[i] = (cnt_q < d_act_q[i]);
      end
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      dir_q        <= DIR_UP;
      p_act_q      <= '0;
      m_act_q      <= 1'b0;
      pwm_q        <= '0;
      period_end_q <= 1'b0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        s_q[i]     <= '0;
        d_act_q[i] <= '0;
      end
    end else begin
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      p_act_q      <= p_act_d;
      m_act_q      <= m_act_d;
      pwm_q        <= pwm_d;
      period_end_q <= period_end_d;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        s_q[i]     <= s_d[i];
        d_act_q[i] <= d_act_d[i];
      end
    end
  end

  assign pwm        = pwm_q;
  assign period_end = period_end_q;
  assign count      = cnt_q;

endmodule

// File: tb/tb_pwm_multi_generator.sv
// Self-checking bench for pwm_multi_generator (WIDTH=10, CHANNELS=4), with a
// second CHANNELS=5 instance for out-of-range write indices.
module tb_pwm_multi_generator;

  logic       CLK;
  logic       reset;
  logic       enable;
  logic       center_mode;
  logic [9:0] period;
  logic       wr_en;
  logic [1:0] wr_ch;
  logic [9:0] wr_duty;
  logic       wr_ready;
  logic [3:0] pwm;
  logic       period_end;
  logic [9:0] count;

  logic       wr_en2;
  logic [2:0] wr_ch2;
  logic       wr_ready2;
  logic [4:0] pwm2;
  logic       period_end2;
  logic [9:0] count2;

  pwm_multi_generator #(.WIDTH(10), .CHANNELS(4)) dut (
    .CLK(CLK), .reset(reset), .enable(enable), .center_mode(center_mode),
    .period(period), .wr_en(wr_en), .wr_ch(wr_ch), .wr_duty(wr_duty),
    .wr_ready(wr_ready), .pwm(pwm), .period_end(period_end), .count(count)
  );

  pwm_multi_generator #(.WIDTH(10), .CHANNELS(5)) dut5 (
    .CLK(CLK), .reset(reset), .enable(enable), .center_mode(center_mode),
    .period(period), .wr_en(wr_en2), .wr_ch(wr_ch2), .wr_duty(wr_duty),
    .wr_ready(wr_ready2), .pwm(pwm2), .period_end(period_end2), .count(count2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string      tag;
    logic [9:0] cnt;
    logic [3:0] pwm;
    logic       pe;
  } exp_t;

  typedef struct {
    logic       en;
    logic       center;
    logic [9:0] period;
    logic       we;
    logic [1:0] ch;
    logic [9:0] duty;
    logic       rdy;
    logic [9:0] cnt;
    logic [3:0] pwm;
    logic       pe;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[9];
  int   cs[8];
  int   checks = 0;
  int   errors = 0;
  int   c, pn, d0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Wait for the next active edge, then compare against the oldest expectation.
  task automatic tick();
    exp_t e;
    @(posedge CLK);
    #1;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty actual=0 required=1");
    end else begin
      e = sbq.pop_front();
      chk({e.tag, "_count"}, 32'(count), 32'(e.cnt));
      chk({e.tag, "_pwm"}, 32'(pwm), 32'(e.pwm));
      chk({e.tag, "_period_end"}, 32'(period_end), 32'(e.pe));
    end
  endtask

  // One clock cycle: drive inputs, check wr_ready for this cycle, queue the
  // outputs expected after the edge, then advance.
  task automatic cyc(input string tag, input logic en, input logic we, input logic [1:0] ch,
                     input logic [9:0] duty, input logic rdy,
                     input logic [9:0] ec, input logic [3:0] ep, input logic epe);
    exp_t e;
    enable  = en;
    wr_en   = we;
    wr_ch   = ch;
    wr_duty = duty;
    #1;
    chk({tag, "_wr_ready"}, 32'(wr_ready), 32'(rdy));
    e.tag = tag;
    e.cnt = ec;
    e.pwm = ep;
    e.pe  = epe;
    sbq.push_back(e);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    // Edge period 3: S0=1, S3=4 (4 > 3 -> always high), then run and idle.
    tbl[0] = '{1'b0, 1'b0, 10'd3, 1'b1, 2'd0, 10'd1, 1'b1, 10'd0, 4'b0000, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 10'd3, 1'b1, 2'd3, 10'd4, 1'b1, 10'd0, 4'b0000, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 10'd3, 1'b0, 2'd0, 10'd0, 1'b1, 10'd0, 4'b0000, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 10'd3, 1'b0, 2'd0, 10'd0, 1'b1, 10'd1, 4'b1001, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 10'd3, 1'b0, 2'd0, 10'd0, 1'b1, 10'd2, 4'b1000, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 10'd3, 1'b0, 2'd0, 10'd0, 1'b1, 10'd3, 4'b1000, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 10'd3, 1'b0, 2'd0, 10'd0, 1'b0, 10'd0, 4'b1000, 1'b1};
    tbl[7] = '{1'b1, 1'b0, 10'd3, 1'b0, 2'd0, 10'd0, 1'b1, 10'd1, 4'b1001, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 10'd3, 1'b0, 2'd0, 10'd0, 1'b1, 10'd0, 4'b0000, 1'b0};
    cs = '{0, 1, 2, 3, 4, 3, 2, 1};

    reset       = 1'b0;
    enable      = 1'b0;
    center_mode = 1'b0;
    period      = 10'd3;
    wr_en       = 1'b0;
    wr_ch       = 2'd0;
    wr_duty     = 10'd0;
    wr_en2      = 1'b0;
    wr_ch2      = 3'd0;

    #1 reset = 1'b1;
    #1;
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_pwm", 32'(pwm), 32'd0);
    chk("reset_period_end", 32'(period_end), 32'd0);
    chk("reset_wr_ready", 32'(wr_ready), 32'd1);
    #1 reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      period      = tbl[i].period;
      center_mode = tbl[i].center;
      cyc($sformatf("vec%0d", i), tbl[i].en, tbl[i].we, tbl[i].ch, tbl[i].duty,
          tbl[i].rdy, tbl[i].cnt, tbl[i].pwm, tbl[i].pe);
    end

    // Edge mode, period 9: S0=3, S1=0, S2=10 (>P), S3=9.
    period = 10'd9;
    cyc("setA", 1'b0, 1'b1, 2'd0, 10'd3, 1'b1, 10'd0, 4'b0000, 1'b0);
    cyc("setA", 1'b0, 1'b1, 2'd1, 10'd0, 1'b1, 10'd0, 4'b0000, 1'b0);
    cyc("setA", 1'b0, 1'b1, 2'd2, 10'd10, 1'b1, 10'd0, 4'b0000, 1'b0);
    cyc("setA", 1'b0, 1'b1, 2'd3, 10'd9, 1'b1, 10'd0, 4'b0000, 1'b0);
    cyc("setA", 1'b0, 1'b0, 2'd0, 10'd0, 1'b1, 10'd0, 4'b0000, 1'b0);
    // k=15: write S0=5 at cnt=4 (visible from the third period on).
    // k=30: write S1=7 in the terminal cycle (must be dropped).
    for (int k = 1; k <= 44; k++) begin
      c  = (k - 1) % 10;
      pn = (k - 1) / 10;
      d0 = (pn >= 2) ? 5 : 3;
      cyc("edge", 1'b1, (k == 15) || (k == 30), (k == 30) ? 2'd1 : 2'd0,
          (k == 30) ? 10'd7 : 10'd5, (c != 9), 10'(k % 10),
          {(c < 9), 1'b1, 1'b0, (c < d0)}, ((k % 10) == 0));
    end

    // Drop enable mid-period (cnt=4), change period and S0 while idle.
    period = 10'd5;
    cyc("dis", 1'b0, 1'b0, 2'd0, 10'd0, 1'b1, 10'd0, 4'b0000, 1'b0);
    cyc("dis", 1'b0, 1'b1, 2'd0, 10'd2, 1'b1, 10'd0, 4'b0000, 1'b0);
    cyc("dis", 1'b0, 1'b0, 2'd0, 10'd0, 1'b1, 10'd0, 4'b0000, 1'b0);
    for (int k = 1; k <= 14; k++) begin
      c = (k - 1) % 6;
      cyc("restart", 1'b1, 1'b0, 2'd0, 10'd0, (c != 5), 10'(k % 6),
          {1'b1, 1'b1, 1'b0, (c < 2)}, ((k % 6) == 0));
    end

    // Center mode, period 4, S0=2.
    center_mode = 1'b1;
    period      = 10'd4;
    cyc("cdis", 1'b0, 1'b0, 2'd0, 10'd0, 1'b1, 10'd0, 4'b0000, 1'b0);
    cyc("cdis", 1'b0, 1'b0, 2'd0, 10'd0, 1'b1, 10'd0, 4'b0000, 1'b0);
    for (int k = 1; k <= 24; k++) begin
      c = cs[(k - 1) % 8];
      cyc("center", 1'b1, 1'b0, 2'd0, 10'd0, (((k - 1) % 8) != 7), 10'(cs[k % 8]),
          {1'b1, 1'b1, 1'b0, (c < 2)}, ((k % 8) == 0));
    end

    // Async reset at cnt=6 of period 9, between edges.
    center_mode = 1'b0;
    period      = 10'd9;
    cyc("edis", 1'b0, 1'b0, 2'd0, 10'd0, 1'b1, 10'd0, 4'b0000, 1'b0);
    cyc("edis", 1'b0, 1'b0, 2'd0, 10'd0, 1'b1, 10'd0, 4'b0000, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      c = k - 1;
      cyc("pre_rst", 1'b1, 1'b0, 2'd0, 10'd0, 1'b1, 10'(k),
          {1'b1, 1'b1, 1'b0, (c < 2)}, 1'b0);
    end
    #3 reset = 1'b1;
    #1;
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_pwm", 32'(pwm), 32'd0);
    chk("async_rst_period_end", 32'(period_end), 32'd0);
    enable = 1'b0;
    @(posedge CLK);
    #1;
    chk("held_rst_count", 32'(count), 32'd0);
    chk("held_rst_pwm", 32'(pwm), 32'd0);
    reset = 1'b0;

    // Idle after reset; the CHANNELS=5 instance gets writes to 5, 7 and 4.
    wr_en2 = 1'b1;
    wr_ch2 = 3'd5;
    cyc("post_rst", 1'b0, 1'b0, 2'd0, 10'd10, 1'b1, 10'd0, 4'b0000, 1'b0);
    wr_ch2 = 3'd7;
    cyc("post_rst", 1'b0, 1'b0, 2'd0, 10'd10, 1'b1, 10'd0, 4'b0000, 1'b0);
    wr_ch2 = 3'd4;
    cyc("post_rst", 1'b0, 1'b0, 2'd0, 10'd10, 1'b1, 10'd0, 4'b0000, 1'b0);
    wr_en2 = 1'b0;
    cyc("post_rst", 1'b0, 1'b0, 2'd0, 10'd0, 1'b1, 10'd0, 4'b0000, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      c = (k - 1) % 10;
      cyc("after_rst", 1'b1, 1'b0, 2'd0, 10'd0, (c != 9), 10'(k % 10),
          4'b0000, ((k % 10) == 0));
      chk("ch5_pwm", 32'(pwm2), 32'b10000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
